// File: rtl/dadda_arb_pkg.sv
// Shared types and widths for the shared 64x64 multiplier arbiter.
package dadda_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int OPND_W      = 64;
  localparam int PROD_W      = 128;
  localparam int DEF_NUM_REQ = 4;

endpackage

// File: rtl/dadda_rr_arbiter.sv
// Round-robin grant logic: priority starts one above the last granted index.
module dadda_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic               update,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] cand;
  logic            found;

  // Scan from the pointer upwards, wrapping, and take the first request seen.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (update) begin
      ptr <= (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + ID_W'(1);
    end
  end

endmodule

// File: rtl/dadda_unsigned_multiplier_CLA_64.sv
// Combinational 64x64 unsigned multiplier giving the full 128-bit product.
module dadda_unsigned_multiplier_CLA_64
  import dadda_arb_pkg::*;
(
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  output logic [PROD_W-1:0] p
);

  assign p = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/dadda_mul_arbiter_64.sv
// Shares one 64x64 multiplier among NUM_REQ requesters with a held response.
// Optional per-requester and completion statistics: DADDA_ARB_STATS_EN.
module dadda_mul_arbiter_64
  import dadda_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*OPND_W-1:0] req_a,
  input  logic [NUM_REQ*OPND_W-1:0] req_b,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [PROD_W-1:0]         resp_product
`ifdef DADDA_ARB_STATS_EN
  ,
  output logic [31:0]               op_count,
  output logic [NUM_REQ*32-1:0]     grant_count
`endif
);

  state_t                 state;
  state_t                 state_n;
  logic                   grant_en;
  logic                   accept;
  logic [NUM_REQ-1:0]     gnt;
  logic [ID_W-1:0]        gnt_idx;
  logic [ID_W-1:0]        id_q;
  logic [OPND_W-1:0]      a_sel;
  logic [OPND_W-1:0]      b_sel;
  logic [OPND_W-1:0]      opa;
  logic [OPND_W-1:0]      opb;
  logic [PROD_W-1:0]      prod;

  dadda_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid),
    .en     (grant_en),
    .update (accept),
    .gnt    (gnt),
    .idx    (gnt_idx)
  );

  dadda_unsigned_multiplier_CLA_64 u_mul (
    .a (opa),
    .b (opb),
    .p (prod)
  );

  assign accept     = |gnt;
  assign req_ready  = gnt;
  assign resp_valid = (state == RESP);

  // A grant is possible when idle, or when the held response leaves this cycle.
  always_comb begin
    grant_en = 1'b0;
    state_n  = state;
    case (state)
      IDLE: begin
        grant_en = 1'b1;
        if (accept) state_n = MUL;
      end
      MUL: begin
        state_n = RESP;
      end
      RESP: begin
        grant_en = resp_ready;
        if (resp_ready) state_n = accept ? MUL : IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        a_sel = req_a[i*OPND_W +: OPND_W];
        b_sel = req_b[i*OPND_W +: OPND_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Operands are captured at grant; the product leaves the multiplier in MUL.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa          <= '0;
      opb          <= '0;
      id_q         <= '0;
      resp_id      <= '0;
      resp_product <= '0;
    end else begin
      if (accept) begin
        opa  <= a_sel;
        opb  <= b_sel;
        id_q <= gnt_idx;
      end
      if (state == MUL) begin
        resp_product <= prod;
        resp_id      <= id_q;
      end
    end
  end

`ifdef DADDA_ARB_STATS_EN
  logic [31:0] gcnt [NUM_REQ];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_count <= '0;
      for (int i = 0; i < NUM_REQ; i++) gcnt[i] <= '0;
    end else begin
      if (resp_valid && resp_ready) op_count <= op_count + 32'd1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i]) gcnt[i] <= gcnt[i] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_gcnt
    assign grant_count[g*32 +: 32] = gcnt[g];
  end
`endif

endmodule

// File: tb/tb_dadda_mul_arbiter_64.sv
// Randomised bench for dadda_mul_arbiter_64 against a transaction-level model.
module tb_dadda_mul_arbiter_64;

  localparam int N    = 4;
  localparam int ID_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*64-1:0]  req_a;
  logic [N*64-1:0]  req_b;
  logic             resp_valid;
  logic             resp_ready;
  logic [ID_W-1:0]  resp_id;
  logic [127:0]     resp_product;
`ifdef DADDA_ARB_STATS_EN
  logic [31:0]      op_count;
  logic [N*32-1:0]  grant_count;
  logic [31:0]      mOps;
  logic [31:0]      mGrants [N];
`endif

  int compared;
  int mismatched;
  bit checkEn;

  // Model: at most one product in flight and one held for the consumer.
  bit              mInflight;
  bit              mHeld;
  logic [127:0]    mPendProd;
  logic [127:0]    mExpProd;
  logic [ID_W-1:0] mPendId;
  logic [ID_W-1:0] mExpId;
  int              mPtr;
  int              mLastGrant;

  int fairSeq [5] = '{0, 1, 2, 3, 0};

  dadda_mul_arbiter_64 #(
    .NUM_REQ (N),
    .ID_W    (ID_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product)
`ifdef DADDA_ARB_STATS_EN
    ,
    .op_count     (op_count),
    .grant_count  (grant_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int modelWinner();
    if (mInflight || (mHeld && !resp_ready)) return -1;
    for (int k = 0; k < N; k++) begin
      int c = (mPtr + k) % N;
      if (req_valid[c]) return c;
    end
    return -1;
  endfunction

  task automatic modelStep();
    int w;
    if (!rst_n) begin
      mInflight  = 0;
      mHeld      = 0;
      mPtr       = 0;
      mLastGrant = -1;
      mExpProd   = '0;
      mExpId     = '0;
`ifdef DADDA_ARB_STATS_EN
      mOps = '0;
      for (int i = 0; i < N; i++) mGrants[i] = '0;
`endif
    end else begin
      w = modelWinner();
      if (mHeld && resp_ready) begin
        mHeld = 0;
`ifdef DADDA_ARB_STATS_EN
        mOps = mOps + 32'd1;
`endif
      end
      if (mInflight) begin
        mHeld     = 1;
        mExpProd  = mPendProd;
        mExpId    = mPendId;
        mInflight = 0;
      end
      mLastGrant = w;
      if (w >= 0) begin
        mInflight = 1;
        mPendId   = ID_W'(w);
        mPendProd = {64'b0, req_a[w*64 +: 64]} * {64'b0, req_b[w*64 +: 64]};
        mPtr      = (w + 1) % N;
`ifdef DADDA_ARB_STATS_EN
        mGrants[w] = mGrants[w] + 32'd1;
`endif
      end
    end
  endtask

  always @(posedge clk) modelStep();

  // Every cycle, compare the DUT against what the model says must be visible.
  always @(negedge clk) begin
    if (checkEn) begin
      int w;
      w = modelWinner();
      checkOutput("req_ready", {124'b0, req_ready}, (w >= 0) ? (128'd1 << w) : 128'd0);
      checkOutput("resp_valid", {127'b0, resp_valid}, {127'b0, mHeld});
      if (mHeld) begin
        checkOutput("resp_id", {126'b0, resp_id}, {126'b0, mExpId});
        checkOutput("resp_product", resp_product, mExpProd);
      end
`ifdef DADDA_ARB_STATS_EN
      checkOutput("op_count", {96'b0, op_count}, {96'b0, mOps});
      for (int i = 0; i < N; i++)
        checkOutput("grant_count", {96'b0, grant_count[i*32 +: 32]}, {96'b0, mGrants[i]});
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReq(input int i, input logic [63:0] a, input logic [63:0] b);
    req_a[i*64 +: 64] = a;
    req_b[i*64 +: 64] = b;
  endtask

  function automatic logic [63:0] randOpnd();
    case ($urandom_range(7))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Requesters hold their request until granted, with an occasional early drop.
  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      if (req_valid[i] && mLastGrant != i) begin
        if ($urandom_range(31) == 0) req_valid[i] = 1'b0;
      end else if ($urandom_range(1) == 0) begin
        req_valid[i] = 1'b1;
        setReq(i, randOpnd(), randOpnd());
      end else begin
        req_valid[i] = 1'b0;
      end
    end
    resp_ready = ($urandom_range(9) < 7);
    rst_n      = ($urandom_range(299) != 0);
  endtask

  initial begin
    bit seen;
    compared   = 0;
    mismatched = 0;
    checkEn    = 0;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;
    tick();
    tick();
    rst_n   = 1'b1;
    checkEn = 1;

    @(negedge clk);
    checkOutput("rst_req_ready", {124'b0, req_ready}, 128'd0);
    checkOutput("rst_resp_valid", {127'b0, resp_valid}, 128'd0);
    checkOutput("rst_resp_id", {126'b0, resp_id}, 128'd0);
    checkOutput("rst_resp_product", resp_product, 128'd0);

    tick();
    req_valid = 4'b0100;
    setReq(2, 64'd3, 64'd5);
    resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("single_grant", {124'b0, req_ready}, 128'h4);
    tick();
    req_valid = '0;
    @(negedge clk);
    checkOutput("single_mul_cycle", {127'b0, resp_valid}, 128'd0);
    tick();
    @(negedge clk);
    checkOutput("single_valid", {127'b0, resp_valid}, 128'd1);
    checkOutput("single_product", resp_product, 128'd15);
    checkOutput("single_id", {126'b0, resp_id}, 128'd2);

    tick();
    req_valid = 4'b0010;
    setReq(1, '1, '1);
    @(negedge clk);
    checkOutput("max_grant", {124'b0, req_ready}, 128'h2);
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    checkOutput("max_product", resp_product, 128'hFFFFFFFFFFFFFFFE0000000000000001);
    checkOutput("max_id", {126'b0, resp_id}, 128'd1);

    tick();
    req_valid = 4'b0001;
    setReq(0, 64'h5829EC10, 64'd1);
    tick();
    req_valid = '0;
    tick();
    @(negedge clk);
    checkOutput("one_product", resp_product, 128'h5829EC10);
    checkOutput("one_id", {126'b0, resp_id}, 128'd0);

    tick();
    req_valid = 4'b1000;
    setReq(3, 64'd7, 64'd9);
    @(negedge clk);
    checkOutput("rstm_grant", {124'b0, req_ready}, 128'h8);
    tick();
    req_valid = '0;
    rst_n     = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rstm_valid", {127'b0, resp_valid}, 128'd0);
    checkOutput("rstm_id", {126'b0, resp_id}, 128'd0);
    checkOutput("rstm_product", resp_product, 128'd0);
`ifdef DADDA_ARB_STATS_EN
    checkOutput("rstm_op_count", {96'b0, op_count}, 128'd0);
`endif
    tick();
    @(negedge clk);
    checkOutput("rstm_no_resp", {127'b0, resp_valid}, 128'd0);

    tick();
    for (int i = 0; i < N; i++) setReq(i, 64'(i + 10), 64'(i + 20));
    req_valid  = '1;
    resp_ready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      @(negedge clk);
      checkOutput("fair_valid", {127'b0, resp_valid}, (c >= 2 && c % 2 == 0) ? 128'd1 : 128'd0);
      if (c >= 2 && c % 2 == 0) begin
        checkOutput("fair_id", {126'b0, resp_id}, 128'(fairSeq[c/2 - 1]));
        checkOutput("fair_product", resp_product,
                    128'((fairSeq[c/2 - 1] + 10) * (fairSeq[c/2 - 1] + 20)));
      end
    end

    tick();
    resp_ready = 1'b0;
    seen = 0;
    for (int k = 0; k < 5 && !seen; k++) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    checkOutput("bp_reach_resp", {127'b0, seen}, 128'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checkOutput("bp_ready", {124'b0, req_ready}, 128'd0);
      checkOutput("bp_valid", {127'b0, resp_valid}, 128'd1);
      checkOutput("bp_id", {126'b0, resp_id}, 128'd1);
      checkOutput("bp_product", resp_product, 128'd231);
    end
    tick();
    resp_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_release_grant", {124'b0, req_ready}, 128'h4);

    repeat (3000) begin
      tick();
      applyStimulus();
    end

    tick();
    rst_n     = 1'b1;
    req_valid = '0;
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
